// File: rtl/cpu_cs_loader.sv
// Writable-control-store loader: pulls 16-bit source slices, writes each
// 64-bit microword as four strobed slice writes, and optionally reads the
// word back and compares it before moving on to the next microaddress.
module cpu_cs_loader (
    input  logic        sysclk,
    input  logic        sys_rst,
    input  logic        START,
    input  logic [11:0] BASE_ADDR,
    input  logic [12:0] WORD_COUNT,
    input  logic        VERIFY,
    input  logic [15:0] SRC_DATA,
    input  logic        SRC_VALID,
    output logic        SRC_READY,
    input  logic [63:0] CSBITS_IN,
    output logic [11:0] LUA_11_0,
    output logic [15:0] IDB_OUT,
    output logic [3:0]  WW_3_0_n,
    output logic        RDCS_n,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [11:0] ERR_ADDR
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_RD1    = 3'd4;
    localparam logic [2:0] S_RD2    = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [1:0]  slice_q, slice_d;
    logic [11:0] lua_q, lua_d;
    logic [15:0] idb_q, idb_d;
    logic [12:0] remaining_q, remaining_d;
    logic        verify_q, verify_d;
    logic        err_q, err_d;
    logic [11:0] err_addr_q, err_addr_d;
    logic [63:0] word_q, word_d;
    logic        advance;

    // Next-state and datapath update for the load sequencer
    always_comb begin
        state_d     = state_q;
        slice_d     = slice_q;
        lua_d       = lua_q;
        idb_d       = idb_q;
        remaining_d = remaining_q;
        verify_d    = verify_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        word_d      = word_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (WORD_COUNT == 13'd0) begin
                        state_d = S_FIN;
                    end else begin
                        lua_d       = BASE_ADDR;
                        remaining_d = WORD_COUNT;
                        verify_d    = VERIFY;
                        slice_d     = 2'd0;
                        err_d       = 1'b0;
                        err_addr_d  = 12'd0;
                        state_d     = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (SRC_VALID) begin
                    idb_d                           = SRC_DATA;
                    word_d[{slice_q, 4'b0000} +: 16] = SRC_DATA;
                    state_d                         = S_STROBE;
                end
            end
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                if (slice_q != 2'd3) begin
                    slice_d = slice_q + 2'd1;
                    state_d = S_FETCH;
                end else if (verify_q) begin
                    state_d = S_RD1;
                end else begin
                    advance = 1'b1;
                end
            end
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                if (CSBITS_IN != word_q) begin
                    // Abort on the first bad word; the address stays on it
                    err_d      = 1'b1;
                    err_addr_d = lua_q;
                    state_d    = S_FIN;
                end else begin
                    advance = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Step to the next microword; the address wraps naturally at 4096
        if (advance) begin
            remaining_d = remaining_q - 13'd1;
            lua_d       = lua_q + 12'd1;
            slice_d     = 2'd0;
            state_d     = (remaining_q == 13'd1) ? S_FIN : S_FETCH;
        end
    end

    // Control and externally visible registers, synchronously reset
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            slice_q     <= 2'd0;
            lua_q       <= 12'd0;
            idb_q       <= 16'd0;
            remaining_q <= 13'd0;
            verify_q    <= 1'b0;
            err_q       <= 1'b0;
            err_addr_q  <= 12'd0;
        end else begin
            state_q     <= state_d;
            slice_q     <= slice_d;
            lua_q       <= lua_d;
            idb_q       <= idb_d;
            remaining_q <= remaining_d;
            verify_q    <= verify_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Assembled microword; only meaningful once all four slices are captured
    always_ff @(posedge sysclk) begin
        word_q <= word_d;
    end

    // Output decode straight from registered state
    always_comb begin
        SRC_READY = (state_q == S_FETCH);
        WW_3_0_n  = (state_q == S_STROBE) ? ~(4'b0001 << slice_q) : 4'hF;
        RDCS_n    = !((state_q == S_RD1) || (state_q == S_RD2));
        BUSY      = (state_q != S_IDLE);
        DONE      = (state_q == S_FIN);
        LUA_11_0  = lua_q;
        IDB_OUT   = idb_q;
        ERR       = err_q;
        ERR_ADDR  = err_addr_q;
    end

endmodule

// File: tb/tb_cpu_cs_loader.sv
// Randomized bench for cpu_cs_loader: a source driver feeds slices, a WCS
// read-back model answers by address, and a monitor logs every slice write
// for comparison against the write list implied by the load request.
module tb_cpu_cs_loader;

    logic        sysclk = 1'b0;
    logic        sys_rst;
    logic        START;
    logic [11:0] BASE_ADDR;
    logic [12:0] WORD_COUNT;
    logic        VERIFY;
    logic [15:0] SRC_DATA;
    logic        SRC_VALID;
    logic        SRC_READY;
    logic [63:0] CSBITS_IN;
    logic [11:0] LUA_11_0;
    logic [15:0] IDB_OUT;
    logic [3:0]  WW_3_0_n;
    logic        RDCS_n;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [11:0] ERR_ADDR;

    always #5 sysclk = ~sysclk;

    cpu_cs_loader dut (
        .sysclk     (sysclk),
        .sys_rst    (sys_rst),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .WORD_COUNT (WORD_COUNT),
        .VERIFY     (VERIFY),
        .SRC_DATA   (SRC_DATA),
        .SRC_VALID  (SRC_VALID),
        .SRC_READY  (SRC_READY),
        .CSBITS_IN  (CSBITS_IN),
        .LUA_11_0   (LUA_11_0),
        .IDB_OUT    (IDB_OUT),
        .WW_3_0_n   (WW_3_0_n),
        .RDCS_n     (RDCS_n),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR),
        .ERR_ADDR   (ERR_ADDR)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request context and source stream
    logic [15:0] src_q[$];
    int          src_ptr;
    int          stall_left;
    int          midstart_at;
    int          cyc_n;
    logic        rand_valid;
    logic [11:0] cur_base;
    int          cur_count;
    int          corrupt_idx;
    logic [63:0] corrupt_mask;

    // Observed writes and events
    logic [11:0] wr_addr[$];
    int          wr_slice[$];
    logic [15:0] wr_data[$];
    int          done_cnt;
    int          first_done_cyc;
    int          ready_cnt;

    // Expected sticky error state carried between loads
    logic        exp_err;
    logic [11:0] exp_err_addr;

    function automatic logic [63:0] word_of(input int i);
        return {src_q[4*i+3], src_q[4*i+2], src_q[4*i+1], src_q[4*i]};
    endfunction

    task automatic fill_random(input int count);
        src_q.delete();
        for (int i = 0; i < 4 * count; i++) src_q.push_back(16'($urandom));
    endtask

    task automatic observe();
        int z;
        int s;
        if (WW_3_0_n !== 4'hF) begin
            z = 0;
            s = 0;
            for (int b = 0; b < 4; b++) begin
                if (!WW_3_0_n[b]) begin
                    z++;
                    s = b;
                end
            end
            chk("ww_single_low", z, 1);
            chk("ww_context_rdy_rdcs_done", {SRC_READY, RDCS_n, DONE}, 3'b010);
            wr_addr.push_back(LUA_11_0);
            wr_slice.push_back(s);
            wr_data.push_back(IDB_OUT);
        end
        if (DONE) begin
            done_cnt++;
            if (first_done_cyc < 0) first_done_cyc = cyc_n;
        end
        if (SRC_READY) ready_cnt++;
    endtask

    task automatic drive();
        int idx;
        START = 1'b0;
        if (cyc_n == midstart_at) begin
            START      = 1'b1;
            BASE_ADDR  = 12'h555;
            WORD_COUNT = 13'd7;
            VERIFY     = 1'b1;
        end
        idx = int'(12'(LUA_11_0 - cur_base));
        if (idx < cur_count)
            CSBITS_IN = word_of(idx) ^ ((idx == corrupt_idx) ? corrupt_mask : 64'd0);
        else
            CSBITS_IN = {$urandom, $urandom};
        if (SRC_READY) begin
            if (stall_left > 0 && (src_ptr % 4) == 2) begin
                SRC_VALID = 1'b0;
                stall_left--;
            end else if (rand_valid && $urandom_range(0, 2) == 0) begin
                SRC_VALID = 1'b0;
            end else if (src_ptr < src_q.size()) begin
                SRC_VALID = 1'b1;
                SRC_DATA  = src_q[src_ptr];
                src_ptr++;
            end else begin
                SRC_VALID = 1'b0;
            end
        end else begin
            SRC_VALID = 1'($urandom);
            SRC_DATA  = 16'($urandom);
        end
    endtask

    task automatic cyc();
        @(negedge sysclk);
        cyc_n++;
        observe();
        drive();
    endtask

    task automatic setup(input logic [11:0] base, input int count, input logic verify,
                         input int corrupt, input int stall, input int midstart, input logic rv);
        wr_addr.delete();
        wr_slice.delete();
        wr_data.delete();
        cur_base       = base;
        cur_count      = count;
        corrupt_idx    = corrupt;
        corrupt_mask   = 64'd1 << $urandom_range(0, 63);
        src_ptr        = 0;
        stall_left     = stall;
        midstart_at    = midstart;
        rand_valid     = rv;
        cyc_n          = 0;
        done_cnt       = 0;
        first_done_cyc = -1;
        ready_cnt      = 0;
        START          = 1'b1;
        BASE_ADDR      = base;
        WORD_COUNT     = 13'(count);
        VERIFY         = verify;
        SRC_VALID      = 1'b0;
    endtask

    task automatic run_load(input logic [11:0] base, input int count, input logic verify,
                            input int corrupt, input int stall, input int midstart,
                            input logic rv, input int exp_lat);
        int nw;
        int n;
        logic bad;
        setup(base, count, verify, corrupt, stall, midstart, rv);
        for (int i = 0; i < 3000 && first_done_cyc < 0; i++) cyc();
        if (first_done_cyc < 0) chk("done_timeout", 0, 1);
        for (int i = 0; i < 3; i++) cyc();

        bad = verify && (corrupt >= 0);
        nw  = bad ? corrupt + 1 : count;
        if (count > 0) begin
            exp_err      = bad;
            exp_err_addr = bad ? 12'(base + corrupt) : 12'd0;
        end

        chk("done_pulses", done_cnt, 1);
        if (exp_lat >= 0) chk("done_latency", first_done_cyc, exp_lat);
        chk("write_count", wr_addr.size(), 4 * nw);
        n = (wr_addr.size() < 4 * nw) ? wr_addr.size() : 4 * nw;
        for (int k = 0; k < n; k++)
            chk("write_addr_slice_data", {wr_addr[k], 8'(wr_slice[k]), wr_data[k]},
                {12'(base + k / 4), 8'(k % 4), src_q[k]});
        chk("slices_consumed", src_ptr, 4 * nw);
        chk("err", ERR, exp_err);
        chk("err_addr", ERR_ADDR, exp_err_addr);
        chk("busy_after_done", BUSY, 0);
        if (count > 0)
            chk("final_lua", LUA_11_0, bad ? 12'(base + corrupt) : 12'(base + count));
        else
            chk("ready_never_for_zero", ready_cnt, 0);
    endtask

    initial begin
        int cnt;
        int cor;
        logic vf;
        logic [11:0] b;

        sys_rst    = 1'b1;
        START      = 1'b0;
        BASE_ADDR  = 12'd0;
        WORD_COUNT = 13'd0;
        VERIFY     = 1'b0;
        SRC_DATA   = 16'd0;
        SRC_VALID  = 1'b0;
        CSBITS_IN  = 64'd0;
        exp_err    = 1'b0;
        exp_err_addr = 12'd0;
        cur_count  = 0;
        cur_base   = 12'd0;
        corrupt_idx = -1;
        midstart_at = -1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_outputs", {WW_3_0_n, RDCS_n, SRC_READY, BUSY, DONE, ERR},
            {4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("rst_values", {LUA_11_0, IDB_OUT, ERR_ADDR}, 40'd0);
        sys_rst = 1'b0;
        @(negedge sysclk);

        // Single word, fixed slices, no stalls
        src_q.delete();
        src_q.push_back(16'h1111);
        src_q.push_back(16'h2222);
        src_q.push_back(16'h3333);
        src_q.push_back(16'h4444);
        run_load(12'h010, 1, 1'b0, -1, 0, -1, 1'b0, 13);

        // Address wrap from 0xFFF to 0x000
        fill_random(2);
        run_load(12'hFFF, 2, 1'b0, -1, 0, -1, 1'b0, 25);

        // Read-back: good word at 0x020, bad at 0x021, nothing at 0x022
        fill_random(3);
        run_load(12'h020, 3, 1'b1, 1, 0, -1, 1'b0, -1);

        // Zero-length request
        fill_random(0);
        run_load(12'h123, 0, 1'b1, -1, 0, -1, 1'b0, 1);

        // Five-cycle stall in slice 2 plus an ignored mid-load START
        fill_random(2);
        run_load(12'h300, 2, 1'b0, -1, 5, 5, 1'b0, 30);

        // Clean verified load with a one-word throughput of 14 cycles
        fill_random(2);
        run_load(12'h040, 2, 1'b1, -1, 0, -1, 1'b0, 29);

        // Reset in the middle of the slice-1 strobe; ERR is set from above? no,
        // so first leave an error behind, then reset must clear it
        fill_random(1);
        run_load(12'h0AA, 1, 1'b1, 0, 0, -1, 1'b0, -1);
        fill_random(1);
        setup(12'h700, 1, 1'b0, -1, 0, -1, 1'b0);
        for (int i = 0; i < 100 && WW_3_0_n !== 4'b1101; i++) cyc();
        chk("reached_slice1_strobe", WW_3_0_n, 4'b1101);
        sys_rst = 1'b1;
        cyc();
        chk("rst_mid_outputs", {WW_3_0_n, RDCS_n, SRC_READY, BUSY, DONE, ERR},
            {4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("rst_mid_values", {LUA_11_0, IDB_OUT, ERR_ADDR}, 40'd0);
        sys_rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) cyc();
        chk("no_done_after_rst", done_cnt, 0);
        chk("no_writes_after_rst", wr_addr.size(), 2);
        exp_err      = 1'b0;
        exp_err_addr = 12'd0;

        // Randomized loads with random source gaps
        for (int t = 0; t < 30; t++) begin
            cnt = $urandom_range(0, 3);
            vf  = 1'($urandom);
            cor = (vf && cnt > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, cnt - 1) : -1;
            b   = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
            fill_random(cnt);
            run_load(b, cnt, vf, cor, 0, -1, 1'b1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
